// File: rtl/tcm_stream_loader.sv
// Byte-stream to TCM loader: packs bytes little-endian into words and writes them to consecutive addresses.
// Optional readback verify of each written word is compiled in with `define LOADER_VERIFY_EN.
module tcm_stream_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int N_ENTRIES  = 1024,
    parameter int ADDRW      = $clog2(N_ENTRIES)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDRW-1:0]        base_i,
    input  logic [ADDRW:0]          nwords_i,
    input  logic                    s_valid_i,
    input  logic [7:0]              s_data_i,
    output logic                    s_ready_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDRW-1:0]        mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    input  logic                    mem_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ADDRW:0]          words_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = ADDRW + 1;
    localparam logic [KW-1:0] K_LAST  = KW'(NB - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
`ifdef LOADER_VERIFY_EN
        S_VRD,
        S_VCHK,
`endif
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDRW-1:0]    base_q, base_d;
    logic [CW-1:0]       target_q, target_d;
    logic [CW-1:0]       words_q, words_d;
    logic [KW-1:0]       k_q, k_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    logic                s_ready_q, s_ready_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [NB-1:0]       mem_be_q, mem_be_d;
    logic [ADDRW-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

`ifdef LOADER_VERIFY_EN
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        target_d = target_q;
        words_d  = words_q;
        k_d      = k_q;
        hold_d   = hold_q;
`ifdef LOADER_VERIFY_EN
        err_d    = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d   = base_i;
                    target_d = (nwords_i > CNT_MAX) ? CNT_MAX : nwords_i;
                    words_d  = '0;
                    k_d      = '0;
`ifdef LOADER_VERIFY_EN
                    err_d    = 1'b0;
`endif
                    state_d  = (nwords_i == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                // s_ready_q is high for the whole of COLLECT, so this is the handshake.
                if (s_valid_i && s_ready_q) begin
                    hold_d[8*int'(k_q) +: 8] = s_data_i;
                    k_d = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + CW'(1);
                k_d     = '0;
`ifdef LOADER_VERIFY_EN
                state_d = S_VRD;
`else
                state_d = ((words_q + CW'(1)) == target_q) ? S_DONE : S_COLLECT;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VRD: begin
                state_d = S_VCHK;
            end
            S_VCHK: begin
                // words_q was already advanced by the WRITE this check belongs to.
                if (mem_ready_i) begin
                    if (mem_data_i != hold_q) begin
                        err_d = 1'b1;
                    end
                    state_d = (words_q == target_q) ? S_DONE : S_COLLECT;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        s_ready_d  = (state_d == S_COLLECT);
        done_d     = (state_d == S_DONE);
        mem_we_d   = (state_d == S_WRITE);
        mem_be_d   = (state_d == S_WRITE) ? {NB{1'b1}} : {NB{1'b0}};
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (state_d == S_WRITE) begin
            mem_addr_d = base_q + words_q[ADDRW-1:0];
            mem_data_d = hold_d;
        end
`ifdef LOADER_VERIFY_EN
        mem_en_d = (state_d == S_WRITE) || (state_d == S_VRD);
        busy_d   = (state_d == S_COLLECT) || (state_d == S_WRITE) ||
                   (state_d == S_VRD) || (state_d == S_VCHK);
`else
        mem_en_d = (state_d == S_WRITE);
        busy_d   = (state_d == S_COLLECT) || (state_d == S_WRITE);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            target_q   <= '0;
            words_q    <= '0;
            k_q        <= '0;
            hold_q     <= '0;
            s_ready_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LOADER_VERIFY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            target_q   <= target_d;
            words_q    <= words_d;
            k_q        <= k_d;
            hold_q     <= hold_d;
            s_ready_q  <= s_ready_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef LOADER_VERIFY_EN
            err_q      <= err_d;
`endif
        end
    end

    assign s_ready_o  = s_ready_q;
    assign mem_en_o   = mem_en_q;
    assign mem_we_o   = mem_we_q;
    assign mem_be_o   = mem_be_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign words_o    = words_q;

`ifdef LOADER_VERIFY_EN
    assign err_o = err_q;
`else
    // Readback port is not used without verify.
    logic unused_verify;
    assign unused_verify = ^{mem_data_i, mem_ready_i};
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tcm_stream_loader.sv
// Directed bench for tcm_stream_loader with a behavioural TCM port model.
module tb_tcm_stream_loader;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [9:0]  base_i;
    logic [10:0] nwords_i;
    logic        s_valid_i;
    logic [7:0]  s_data_i;
    logic        s_ready_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [10:0] words_o;

`ifdef LOADER_VERIFY_EN
    localparam int CPW = 7;
`else
    localparam int CPW = 5;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] tcm [0:1023];
    logic [9:0]  wr_log [$];
    logic [7:0]  stream [$];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int bad_ctl = 0;
    int bad_ready = 0;
    int corrupt_idx = -1;

    tcm_stream_loader dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_i(base_i), .nwords_i(nwords_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
    );

    always #5 clk = ~clk;

    // TCM model: 1-cycle read latency, optional corruption of one numbered read.
    always @(posedge clk) begin
        mem_ready_i <= mem_en_o && !mem_we_o;
        mem_data_i  <= tcm[mem_addr_o] ^ ((mem_en_o && !mem_we_o && rd_cnt == corrupt_idx) ? 32'h0000_0100 : 32'h0);
        if (mem_en_o) en_cnt++;
        if (mem_en_o && !mem_we_o) rd_cnt++;
        if (mem_en_o && mem_we_o) begin
            tcm[mem_addr_o] <= mem_data_o;
            wr_cnt++;
            wr_log.push_back(mem_addr_o);
            if (mem_be_o !== 4'hF) bad_ctl++;
        end
        if (!mem_en_o && (mem_we_o || mem_be_o != 4'h0)) bad_ctl++;
        if (s_ready_o && (!busy_o || mem_en_o || done_o)) bad_ready++;
        if (done_o) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a transfer and feeds the stream; returns the cycle in which done_o is seen (-1 on timeout).
    task automatic run_load(input logic [9:0] base, input logic [10:0] n, input bit stall,
                            input bit pulse_start, input int budget, output int cyc_done);
        int  idx;
        bit  drive;
        start_i = 1'b1; base_i = base; nwords_i = n;
        tick();
        start_i = 1'b0;
        idx = 0;
        cyc_done = -1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (done_o) begin
                cyc_done = cyc;
                break;
            end
            drive = (idx < stream.size()) && !(stall && cyc[0]);
            s_valid_i = drive;
            s_data_i  = drive ? stream[idx] : 8'h00;
            if (pulse_start && cyc == 7) begin
                start_i = 1'b1; base_i = 10'h2AA; nwords_i = 11'd5;
            end else begin
                start_i = 1'b0;
            end
            if (drive && s_ready_o) idx++;
            tick();
        end
        s_valid_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        total_cnt++;
        if ({s_ready_o, mem_en_o, mem_we_o, busy_o, done_o, err_o} !== 6'b0)
            $display("FAIL reset_ctl got %b want 000000", {s_ready_o, mem_en_o, mem_we_o, busy_o, done_o, err_o});
        else pass_cnt++;
        total_cnt++;
        if ({mem_be_o, mem_addr_o, mem_data_o, words_o} !== 57'h0)
            $display("FAIL reset_data be=%h addr=%h data=%h words=%0d want all 0", mem_be_o, mem_addr_o, mem_data_o, words_o);
        else pass_cnt++;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cd, wb, db;
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        wb = wr_cnt; db = done_cnt;
        run_load(10'h010, 11'd2, 1'b0, 1'b0, 100, cd);
        total_cnt++;
        if (cd !== 2*CPW + 1) $display("FAIL basic_done_cycle got %0d want %0d", cd, 2*CPW + 1);
        else pass_cnt++;
        total_cnt++;
        if (words_o !== 11'd2) $display("FAIL basic_words got %0d want 2", words_o);
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", busy_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (tcm[10'h010] !== 32'h44332211) $display("FAIL basic_word0 got %h want 44332211", tcm[10'h010]);
        else pass_cnt++;
        total_cnt++;
        if (tcm[10'h011] !== 32'h88776655) $display("FAIL basic_word1 got %h want 88776655", tcm[10'h011]);
        else pass_cnt++;
        total_cnt++;
        if (done_o !== 1'b0 || done_cnt - db !== 1)
            $display("FAIL basic_done_pulse done=%b pulses=%0d want 0 and 1", done_o, done_cnt - db);
        else pass_cnt++;
        total_cnt++;
        if (wr_cnt - wb !== 2) $display("FAIL basic_write_count got %0d want 2", wr_cnt - wb);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int cd, lb;
        stream = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        lb = wr_log.size();
        run_load(10'h3FF, 11'd2, 1'b0, 1'b0, 100, cd);
        tick();
        total_cnt++;
        if (wr_log.size() - lb !== 2 || wr_log[lb] !== 10'h3FF || wr_log[lb+1] !== 10'h000)
            $display("FAIL wrap_addrs n=%0d first=%h second=%h want 2 3ff 000",
                     wr_log.size() - lb, wr_log[lb], wr_log[lb+1]);
        else pass_cnt++;
        total_cnt++;
        if (tcm[10'h3FF] !== 32'hA3A2A1A0 || tcm[10'h000] !== 32'hA7A6A5A4)
            $display("FAIL wrap_data got %h %h want a3a2a1a0 a7a6a5a4", tcm[10'h3FF], tcm[10'h000]);
        else pass_cnt++;
    endtask

    task automatic test_zero_and_saturate();
        int cd, eb, wb;
        stream.delete();
        eb = en_cnt;
        run_load(10'h050, 11'd0, 1'b0, 1'b0, 20, cd);
        total_cnt++;
        if (cd !== 1) $display("FAIL zero_done_cycle got %0d want 1", cd);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (en_cnt - eb !== 0 || words_o !== 11'd0)
            $display("FAIL zero_no_access enables=%0d words=%0d want 0 0", en_cnt - eb, words_o);
        else pass_cnt++;

        for (int i = 0; i < 4096; i++) stream.push_back(i[7:0]);
        wb = wr_cnt;
        run_load(10'h000, 11'd2000, 1'b0, 1'b0, 8000, cd);
        total_cnt++;
        if (cd !== 1024*CPW + 1) $display("FAIL sat_done_cycle got %0d want %0d", cd, 1024*CPW + 1);
        else pass_cnt++;
        total_cnt++;
        if (words_o !== 11'd1024) $display("FAIL sat_words got %0d want 1024", words_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wr_cnt - wb !== 1024) $display("FAIL sat_write_count got %0d want 1024", wr_cnt - wb);
        else pass_cnt++;
        total_cnt++;
        if (tcm[10'h000] !== 32'h03020100 || tcm[10'h3FF] !== 32'hFFFEFDFC)
            $display("FAIL sat_data got %h %h want 03020100 fffefdfc", tcm[10'h000], tcm[10'h3FF]);
        else pass_cnt++;
    endtask

    task automatic test_stall_ignored_start();
        int cd, lb, db;
        stream = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        lb = wr_log.size(); db = done_cnt;
        run_load(10'h100, 11'd2, 1'b1, 1'b1, 200, cd);
        total_cnt++;
        if (cd < 0 || words_o !== 11'd2) $display("FAIL stall_finish cycle=%0d words=%0d want done and 2", cd, words_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (tcm[10'h100] !== 32'hC4C3C2C1 || tcm[10'h101] !== 32'hD4D3D2D1)
            $display("FAIL stall_data got %h %h want c4c3c2c1 d4d3d2d1", tcm[10'h100], tcm[10'h101]);
        else pass_cnt++;
        total_cnt++;
        if (wr_log.size() - lb !== 2 || wr_log[lb] !== 10'h100 || wr_log[lb+1] !== 10'h101)
            $display("FAIL stall_addrs n=%0d first=%h second=%h want 2 100 101",
                     wr_log.size() - lb, wr_log[lb], wr_log[lb+1]);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if (done_cnt - db !== 1 || busy_o !== 1'b0)
            $display("FAIL stall_second_start pulses=%0d busy=%b want 1 0", done_cnt - db, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        int wb;
        wb = wr_cnt;
        start_i = 1'b1; base_i = 10'h200; nwords_i = 11'd1;
        tick();
        start_i = 1'b0;
        s_valid_i = 1'b1; s_data_i = 8'hE0;
        tick();
        s_data_i = 8'hE1;
        tick();
        rst_i = 1'b1; s_data_i = 8'hE2;
        tick();
        total_cnt++;
        if ({s_ready_o, mem_en_o, mem_we_o, busy_o, done_o, err_o} !== 6'b0 ||
            {mem_be_o, mem_addr_o, mem_data_o, words_o} !== 57'h0)
            $display("FAIL midrst_outputs ctl=%b addr=%h data=%h words=%0d want all 0",
                     {s_ready_o, mem_en_o, mem_we_o, busy_o, done_o, err_o}, mem_addr_o, mem_data_o, words_o);
        else pass_cnt++;
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_data_i = 8'hF0 + 8'(i);
            tick();
        end
        s_valid_i = 1'b0;
        total_cnt++;
        if (wr_cnt - wb !== 0 || s_ready_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL midrst_no_write writes=%0d ready=%b busy=%b want 0 0 0", wr_cnt - wb, s_ready_o, busy_o);
        else pass_cnt++;
    endtask

`ifdef LOADER_VERIFY_EN
    task automatic test_verify();
        int cd;
        stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        corrupt_idx = rd_cnt + 1;
        run_load(10'h020, 11'd2, 1'b0, 1'b0, 100, cd);
        total_cnt++;
        if (cd < 0 || err_o !== 1'b1) $display("FAIL verify_err_set cycle=%0d err=%b want done and 1", cd, err_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (err_o !== 1'b1) $display("FAIL verify_err_sticky got %b want 1", err_o);
        else pass_cnt++;
        corrupt_idx = -1;
        run_load(10'h030, 11'd2, 1'b0, 1'b0, 100, cd);
        total_cnt++;
        if (cd !== 2*CPW + 1 || err_o !== 1'b0) $display("FAIL verify_clean cycle=%0d err=%b want 15 0", cd, err_o);
        else pass_cnt++;
        tick();
    endtask
`endif

    task automatic test_port_rules();
        total_cnt++;
        if (bad_ctl !== 0) $display("FAIL port_ctl_rules violations=%0d want 0", bad_ctl);
        else pass_cnt++;
        total_cnt++;
        if (bad_ready !== 0) $display("FAIL ready_outside_collect violations=%0d want 0", bad_ready);
        else pass_cnt++;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; base_i = '0; nwords_i = '0;
        s_valid_i = 1'b0; s_data_i = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_and_saturate();
        test_stall_ignored_start();
        test_reset_mid_word();
`ifdef LOADER_VERIFY_EN
        test_verify();
`endif
        test_port_rules();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
